gt_pattern_player: RTL

- Multi-channel, parametrised pattern playback engine for the GT transmit path.
- Software loads per-channel pattern memories and a playback configuration over the axilite clock domain. A start/stop request crosses to the gt_clk domain, which streams the pattern as a wide parallel word.
- Supports single-shot, continuous-loop and counted-repeat modes, with status returned to the axilite domain.
- Sits between the axilite register file and the GT TX data input.

---
 rtl/gt_pattern_player.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/gt_pattern_player.sv
// Multi-channel pattern playback engine: axilite-side pattern RAMs and control,
// gt_clk-side player FSM streaming one word per channel per beat.
`timescale 1ns/1ps
module gt_pattern_player #(
  parameter int unsigned       NUM_CH    = 6,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_WORD = '0,
  parameter int unsigned       SYNC_FF   = 2,
  localparam int unsigned      CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     axilite_clk,
  input  logic                     axilite_rstb,
  input  logic                     gt_clk,
  input  logic                     gt_rstb,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        cfg_last_addr,
  input  logic [1:0]               cfg_mode,
  input  logic [15:0]              cfg_repeat,
  input  logic                     start,
  input  logic                     stop,
  output logic                     sts_busy,
  output logic                     sts_done,
  output logic [NUM_CH*DATA_W-1:0] gt_data,
  output logic                     gt_valid,
  output logic                     gt_first
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] ModeLoop   = 2'd1;
  localparam logic [1:0] ModeRepeat = 2'd2;

  typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

  // ---------------------------------------------------------------------------
  // Axilite domain: run flag, shadow config, status
  // ---------------------------------------------------------------------------
  logic              r_run;
  logic              r_done;
  logic [ADDR_W-1:0] r_sh_last;
  logic [1:0]        r_sh_mode;
  logic [15:0]       r_sh_rep;
  logic [SYNC_FF-1:0] r_act_sync;
  logic [SYNC_FF-1:0] r_done_sync;
  logic              r_done_s_q;
  logic              w_act_s;
  logic              w_done_s;
  logic              w_busy;
  logic              w_start_ok;
  logic              w_done_rise;

  assign w_act_s     = r_act_sync[SYNC_FF-1];
  assign w_done_s    = r_done_sync[SYNC_FF-1];
  assign w_busy      = r_run | w_act_s | w_done_s;
  assign w_start_ok  = start & ~stop & ~w_busy;
  assign w_done_rise = w_done_s & ~r_done_s_q;

  // gt-side level flags, both produced by registers so they are glitch-free
  logic r_act_lvl;
  logic r_done_lvl;

  always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
    if (!axilite_rstb) begin
      r_act_sync  <= '0;
      r_done_sync <= '0;
      r_done_s_q  <= 1'b0;
    end else begin
      r_act_sync  <= {r_act_sync[SYNC_FF-2:0], r_act_lvl};
      r_done_sync <= {r_done_sync[SYNC_FF-2:0], r_done_lvl};
      r_done_s_q  <= w_done_s;
    end
  end

  always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
    if (!axilite_rstb) begin
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (stop || (w_done_rise && r_run)) begin
        r_run <= 1'b0;
      end else if (w_start_ok) begin
        r_run <= 1'b1;
      end
      if (w_done_rise && r_run) begin
        r_done <= 1'b1;
      end else if (w_start_ok) begin
        r_done <= 1'b0;
      end
    end
  end

  // Shadow config only changes while idle, so the gt side may sample it raw.
  always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
    if (!axilite_rstb) begin
      r_sh_last <= '0;
      r_sh_mode <= '0;
      r_sh_rep  <= '0;
    end else if (w_start_ok) begin
      r_sh_last <= cfg_last_addr;
      r_sh_mode <= cfg_mode;
      r_sh_rep  <= cfg_repeat;
    end
  end

  assign sts_busy = w_busy;
  assign sts_done = r_done;

  // ---------------------------------------------------------------------------
  // gt domain: run synchroniser and player FSM
  // ---------------------------------------------------------------------------
  logic [SYNC_FF-1:0] r_run_sync;
  logic               r_run_s_q;
  logic               w_run_s;
  logic               w_run_rise;

  assign w_run_s    = r_run_sync[SYNC_FF-1];
  assign w_run_rise = w_run_s & ~r_run_s_q;

  // Reset high: a run that is already set when gt_rstb releases must not
  // look like a fresh start; playback needs run to be seen low first.
  always_ff @(posedge gt_clk or negedge gt_rstb) begin
    if (!gt_rstb) begin
      r_run_sync <= '1;
      r_run_s_q  <= 1'b1;
    end else begin
      r_run_sync <= {r_run_sync[SYNC_FF-2:0], r_run};
      r_run_s_q  <= w_run_s;
    end
  end

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [15:0]       r_pass;
  logic [15:0]       w_pass_nxt;
  logic [ADDR_W-1:0] r_last;
  logic [1:0]        r_mode;
  logic [15:0]       r_rep;
  logic              w_cap;
  logic              w_issue;
  logic              r_vld;
  logic              r_first;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_pass_nxt  = r_pass;
    w_cap       = 1'b0;
    w_issue     = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_addr_nxt = '0;
        if (w_run_rise) begin
          w_cap       = 1'b1;
          w_pass_nxt  = '0;
          w_state_nxt = StPlay;
        end
      end
      StPlay: begin
        if (!w_run_s) begin
          w_addr_nxt  = '0;
          w_state_nxt = StIdle;
        end else begin
          w_issue = 1'b1;
          if (r_addr == r_last) begin
            w_addr_nxt = '0;
            case (r_mode)
              ModeLoop: ;
              ModeRepeat: begin
                if (r_pass == r_rep) begin
                  w_state_nxt = StDone;
                end else begin
                  w_pass_nxt = r_pass + 16'd1;
                end
              end
              default: w_state_nxt = StDone;
            endcase
          end else begin
            w_addr_nxt = r_addr + ADDR_W'(1);
          end
        end
      end
      StDone: begin
        w_addr_nxt = '0;
        if (!w_run_s) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_addr_nxt  = '0;
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge gt_clk or negedge gt_rstb) begin
    if (!gt_rstb) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_pass     <= '0;
      r_vld      <= 1'b0;
      r_first    <= 1'b0;
      r_act_lvl  <= 1'b0;
      r_done_lvl <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_pass     <= w_pass_nxt;
      r_vld      <= w_issue;
      r_first    <= w_issue && (r_addr == '0);
      r_act_lvl  <= (w_state_nxt != StIdle);
      r_done_lvl <= (w_state_nxt == StDone);
    end
  end

  always_ff @(posedge gt_clk or negedge gt_rstb) begin
    if (!gt_rstb) begin
      r_last <= '0;
      r_mode <= '0;
      r_rep  <= '0;
    end else if (w_cap) begin
      r_last <= r_sh_last;
      r_mode <= r_sh_mode;
      r_rep  <= r_sh_rep;
    end
  end

  assign gt_valid = r_vld;
  assign gt_first = r_first;

  // ---------------------------------------------------------------------------
  // Per-channel simple dual-port pattern RAMs
  // ---------------------------------------------------------------------------
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_q;

    always_ff @(posedge axilite_clk) begin
      if (wr_en && (wr_ch == CH_W'(ch))) begin
        r_mem[wr_addr] <= wr_data;
      end
    end

    always_ff @(posedge gt_clk) begin
      r_rd_q <= r_mem[r_addr];
    end

    assign gt_data[ch*DATA_W +: DATA_W] = r_vld ? r_rd_q : IDLE_WORD;
  end

endmodule
